// File: rtl/ztft43_bus_responder_if.sv
// rtl/ztft43_bus_responder_if.sv - LCD 8080 bus and event stream bundle for the TFT43 responder
interface ztft43_bus_responder_if;
    logic        LCD_CS;
    logic        LCD_RS;
    logic        LCD_WR;
    logic        LCD_RD;
    logic [15:0] LCD_DATA_I;
    logic [15:0] LCD_DATA_O;
    logic        LCD_DATA_OE;
    logic        ev_valid;
    logic        ev_ready;
    logic        ev_rs;
    logic [15:0] ev_data;

    modport slave (
        input  LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_DATA_I, ev_ready,
        output LCD_DATA_O, LCD_DATA_OE, ev_valid, ev_rs, ev_data
    );

    modport master (
        output LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_DATA_I, ev_ready,
        input  LCD_DATA_O, LCD_DATA_OE, ev_valid, ev_rs, ev_data
    );
endinterface

// File: rtl/ztft43_bus_responder.sv
// rtl/ztft43_bus_responder.sv - TFT43 panel-side 8080 bus responder with event FIFO and bring-up checker
module ztft43_bus_responder #(
    parameter int          FIFO_DEPTH  = 16,
    parameter int          MIN_SLP_CYC = 1200,
    parameter logic [15:0] ID_WORD     = 16'h8000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ztft43_bus_responder_if.slave  bus,
    output logic [15:0]            wr_count,
    output logic                   sleep_out,
    output logic                   disp_on,
    output logic                   err_ovf,
    output logic                   err_seq
);
    localparam int             AW       = $clog2(FIFO_DEPTH);
    localparam int             CW       = $clog2(MIN_SLP_CYC + 1);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]  SLP_MAX  = CW'(MIN_SLP_CYC);
    // Idle bus level: CS, WR, RD high so no strobe edge is invented on reset release
    localparam logic [19:0]    BUS_IDLE = {1'b1, 1'b0, 1'b1, 1'b1, 16'h0000};

    typedef enum logic [1:0] {ST_IDLE, ST_SLP, ST_ON} seq_t;

    logic [19:0] sync1, sync2;
    logic        wr_prev, rd_prev;
    logic        cs_s, rs_s, wr_s, rd_s;
    logic [15:0] dat_s;
    logic        wr_rise, rd_fall;

    logic        cap_valid, cap_rs;
    logic [15:0] cap_data;

    logic [16:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          fifo_full, push, pop;

    logic [15:0] last_cmd, last_dat, rd_val;
    seq_t        state;
    logic [CW-1:0] slp_cnt;

    assign {cs_s, rs_s, wr_s, rd_s, dat_s} = sync2;
    assign wr_rise = wr_s & ~wr_prev & ~cs_s;
    // A write strobe held low alongside RD suppresses the read response
    assign rd_fall = ~rd_s & rd_prev & ~cs_s & wr_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= BUS_IDLE;
            sync2     <= BUS_IDLE;
            wr_prev   <= 1'b1;
            rd_prev   <= 1'b1;
            cap_valid <= 1'b0;
            cap_rs    <= 1'b0;
            cap_data  <= 16'h0000;
        end else begin
            sync1     <= {bus.LCD_CS, bus.LCD_RS, bus.LCD_WR, bus.LCD_RD, bus.LCD_DATA_I};
            sync2     <= sync1;
            wr_prev   <= wr_s;
            rd_prev   <= rd_s;
            cap_valid <= wr_rise;
            cap_rs    <= rs_s;
            cap_data  <= dat_s;
        end
    end

    assign fifo_full    = (count == FULL_CNT);
    assign bus.ev_valid = (count != '0);
    assign pop          = bus.ev_valid & bus.ev_ready;
    assign push         = cap_valid & (~fifo_full | pop);
    assign bus.ev_rs    = bus.ev_valid & mem[rd_ptr][16];
    assign bus.ev_data  = bus.ev_valid ? mem[rd_ptr][15:0] : 16'h0000;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cap_rs, cap_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_count <= 16'h0000;
            err_ovf  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (cap_valid && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            if (cap_valid && !push)                err_ovf  <= 1'b1;
        end
    end

    assign rd_val = (last_cmd inside {16'hDA00, 16'hDB00, 16'hDC00}) ? ID_WORD : last_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_cmd        <= 16'h0000;
            last_dat        <= 16'h0000;
            bus.LCD_DATA_O  <= 16'h0000;
            bus.LCD_DATA_OE <= 1'b0;
        end else begin
            if (cap_valid && !cap_rs) last_cmd <= cap_data;
            if (cap_valid &&  cap_rs) last_dat <= cap_data;
            if (rd_fall) begin
                bus.LCD_DATA_O  <= rd_val;
                bus.LCD_DATA_OE <= 1'b1;
            end else if (rd_s || cs_s) begin
                bus.LCD_DATA_OE <= 1'b0;
            end
        end
    end

    // Bring-up tracker: only command captures move it; the counter runs only while asleep-exiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            slp_cnt   <= '0;
            sleep_out <= 1'b0;
            disp_on   <= 1'b0;
            err_seq   <= 1'b0;
        end else begin
            if (state == ST_SLP && slp_cnt != SLP_MAX) slp_cnt <= slp_cnt + 1'b1;
            if (cap_valid && !cap_rs) begin
                if (cap_data == 16'h1100) begin
                    state     <= ST_SLP;
                    slp_cnt   <= '0;
                    sleep_out <= 1'b1;
                end else if (cap_data == 16'h2900) begin
                    case (state)
                        ST_IDLE: err_seq <= 1'b1;
                        ST_SLP: begin
                            state   <= ST_ON;
                            disp_on <= 1'b1;
                            if (slp_cnt < SLP_MAX) err_seq <= 1'b1;
                        end
                        default: state <= state;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_ztft43_bus_responder.sv
// tb/tb_ztft43_bus_responder.sv - self-checking bench for ztft43_bus_responder
module tb_ztft43_bus_responder;
    localparam int DEPTH = 16;
    localparam int MIN   = 1200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ztft43_bus_responder_if bus();
    logic [15:0] wr_count;
    logic sleep_out, disp_on, err_ovf, err_seq;

    ztft43_bus_responder #(.FIFO_DEPTH(DEPTH), .MIN_SLP_CYC(MIN), .ID_WORD(16'h8000)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .wr_count(wr_count),
        .sleep_out(sleep_out), .disp_on(disp_on), .err_ovf(err_ovf), .err_seq(err_seq)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ready_mode = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: event queue, counters, sticky flags, read shadow
    logic [16:0] mq[$];
    int          m_cnt;
    bit          m_ovf, m_sleep, m_disp, m_err;
    int          m_state;
    int          m_t1100;
    logic [15:0] m_cmd, m_dat;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_cnt = 0; m_ovf = 0; m_sleep = 0; m_disp = 0; m_err = 0;
        m_state = 0; m_t1100 = 0; m_cmd = 16'h0; m_dat = 16'h0;
    endtask

    function automatic logic [15:0] m_read();
        if (m_cmd == 16'hDA00 || m_cmd == 16'hDB00 || m_cmd == 16'hDC00) return 16'h8000;
        return m_dat;
    endfunction

    task automatic m_capture(bit rs, logic [15:0] d);
        if (m_cnt < 65535) m_cnt++;
        if (mq.size() >= DEPTH) m_ovf = 1;
        else mq.push_back({rs, d});
        if (rs) m_dat = d;
        else begin
            m_cmd = d;
            if (d == 16'h1100) begin
                m_sleep = 1; m_state = 1; m_t1100 = cyc;
            end else if (d == 16'h2900) begin
                if (m_state == 0) m_err = 1;
                else if (m_state == 1) begin
                    m_disp = 1;
                    if (cyc - m_t1100 < MIN) m_err = 1;
                    m_state = 2;
                end
            end
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       bus.ev_ready = 1'b0;
            1:       bus.ev_ready = 1'b1;
            default: bus.ev_ready = ($urandom % 4) != 0;
        endcase
    end

    always @(negedge clk) begin
        if (rst_n && bus.ev_valid && bus.ev_ready) begin
            if (mq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL ev_unexpected actual=%h required=none", {bus.ev_rs, bus.ev_data});
            end else begin
                logic [16:0] e;
                e = mq.pop_front();
                chk("ev_head", {15'b0, bus.ev_rs, bus.ev_data}, {15'b0, e});
            end
        end
    end

    task automatic bus_write(bit rs, logic [15:0] d, bit cs_active);
        @(posedge clk); #1;
        bus.LCD_CS = ~cs_active; bus.LCD_RS = rs; bus.LCD_DATA_I = d; bus.LCD_WR = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.LCD_WR = 1'b1;
        if (cs_active) m_capture(rs, d);
        repeat (4) @(posedge clk);
        #1 bus.LCD_CS = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic bus_read(string nm, logic [15:0] exp, int hold);
        int lat;
        @(posedge clk); #1;
        bus.LCD_CS = 1'b0; bus.LCD_RD = 1'b0;
        lat = 0;
        while (!bus.LCD_DATA_OE && lat < 8) begin @(posedge clk); #1; lat++; end
        chk({nm, "_oe_rise_le4"}, 32'(lat <= 4), 32'd1);
        repeat (hold) @(posedge clk);
        #1;
        chk({nm, "_oe"}, 32'(bus.LCD_DATA_OE), 32'd1);
        chk({nm, "_data"}, 32'(bus.LCD_DATA_O), 32'(exp));
        bus.LCD_RD = 1'b1;
        lat = 0;
        while (bus.LCD_DATA_OE && lat < 8) begin @(posedge clk); #1; lat++; end
        chk({nm, "_oe_drop_le4"}, 32'(lat <= 4), 32'd1);
        bus.LCD_CS = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          rs;
        logic [15:0] data;
        bit          rd;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        int   n, base;
        bit   rs;
        logic [15:0] d;

        tbl[0] = '{1'b0, 16'h3600, 1'b0, 16'h0000};
        tbl[1] = '{1'b1, 16'h0048, 1'b0, 16'h0000};
        tbl[2] = '{1'b0, 16'hDA00, 1'b1, 16'h8000};
        tbl[3] = '{1'b0, 16'h2A00, 1'b1, 16'h0048};
        tbl[4] = '{1'b1, 16'h1234, 1'b1, 16'h1234};
        tbl[5] = '{1'b0, 16'hDB00, 1'b1, 16'h8000};
        tbl[6] = '{1'b0, 16'hDC00, 1'b1, 16'h8000};
        tbl[7] = '{1'b0, 16'hDD00, 1'b1, 16'h1234};

        bus.LCD_CS = 1'b1; bus.LCD_RS = 1'b0; bus.LCD_WR = 1'b1; bus.LCD_RD = 1'b1;
        bus.LCD_DATA_I = 16'h0000;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle bus after reset
        seen = 1'b0;
        repeat (100) begin @(posedge clk); #1; seen |= bus.ev_valid; end
        chk("rst_ev_valid", 32'(seen), 32'd0);
        chk("rst_oe", 32'(bus.LCD_DATA_OE), 32'd0);
        chk("rst_data_o", 32'(bus.LCD_DATA_O), 32'd0);
        chk("rst_ev_data", {15'b0, bus.ev_rs, bus.ev_data}, 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        chk("rst_flags", {28'b0, sleep_out, disp_on, err_ovf, err_seq}, 32'd0);

        // Table-driven writes and reads
        ready_mode = 1;
        for (int i = 0; i < 8; i++) begin
            bus_write(tbl[i].rs, tbl[i].data, 1'b1);
            if (i == 1) chk("wr_count_2", 32'(wr_count), 32'd2);
            if (tbl[i].rd) bus_read($sformatf("tbl_rd%0d", i), tbl[i].exp_rd, 10);
        end

        // Exact capture latency
        ready_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        bus.LCD_CS = 1'b0; bus.LCD_RS = 1'b1; bus.LCD_DATA_I = 16'hBEEF; bus.LCD_WR = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.LCD_WR = 1'b1;
        m_capture(1'b1, 16'hBEEF);
        n = 0;
        while (!bus.ev_valid && n < 10) begin @(posedge clk); #1; n++; end
        chk("wr_latency", 32'(n), 32'd4);
        repeat (3) @(posedge clk);
        #1 bus.LCD_CS = 1'b1;
        ready_mode = 1;
        repeat (10) @(posedge clk);

        // WR edge with CS high is ignored
        base = int'(wr_count);
        bus_write(1'b1, 16'h7777, 1'b0);
        repeat (6) @(posedge clk);
        #1 chk("cs_high_ignored", 32'(wr_count), 32'(base));

        // RD and WR low together: write wins, no OE
        @(posedge clk); #1;
        bus.LCD_CS = 1'b0; bus.LCD_RS = 1'b1; bus.LCD_DATA_I = 16'h5A5A;
        bus.LCD_WR = 1'b0; bus.LCD_RD = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(posedge clk); #1; seen |= bus.LCD_DATA_OE; end
        bus.LCD_WR = 1'b1;
        m_capture(1'b1, 16'h5A5A);
        repeat (5) begin @(posedge clk); #1; seen |= bus.LCD_DATA_OE; end
        bus.LCD_RD = 1'b1; bus.LCD_CS = 1'b1;
        chk("wr_wins_no_oe", 32'(seen), 32'd0);
        repeat (6) @(posedge clk);

        // Overflow: 17 writes with consumer stalled
        ready_mode = 0;
        repeat (3) @(posedge clk);
        base = int'(wr_count);
        for (int i = 0; i < 17; i++) bus_write(1'b1, 16'h0100 + 16'(i), 1'b1);
        repeat (6) @(posedge clk);
        #1;
        chk("ovf_ev_valid", 32'(bus.ev_valid), 32'd1);
        chk("ovf_err", 32'(err_ovf), 32'd1);
        chk("ovf_wr_count", 32'(int'(wr_count) - base), 32'd17);
        chk("ovf_model_held", 32'(mq.size()), 32'd16);
        ready_mode = 1;
        repeat (40) @(posedge clk);
        #1;
        chk("ovf_drained", 32'(mq.size()), 32'd0);
        chk("ovf_empty", 32'(bus.ev_valid), 32'd0);

        // Bring-up sequence with sufficient and insufficient delay
        bus_write(1'b0, 16'h1100, 1'b1);
        repeat (1300) @(posedge clk);
        bus_write(1'b0, 16'h2900, 1'b1);
        chk("seq_ok_flags", {29'b0, sleep_out, disp_on, err_seq}, {29'b0, 3'b110});
        bus_write(1'b0, 16'h1100, 1'b1);
        repeat (500) @(posedge clk);
        bus_write(1'b0, 16'h2900, 1'b1);
        chk("seq_short_flags", {29'b0, sleep_out, disp_on, err_seq}, {29'b0, 3'b111});

        // Randomized traffic against the model
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            if (($urandom % 10) < 7) begin
                rs = 1'($urandom % 2);
                case ($urandom % 8)
                    0: d = 16'h1100;
                    1: d = 16'h2900;
                    2: d = 16'hDA00;
                    3: d = 16'hDB00;
                    4: d = 16'hDC00;
                    5: d = 16'h2A00;
                    default: d = 16'($urandom);
                endcase
                bus_write(rs, d, 1'b1);
            end else begin
                bus_read("rnd_rd", m_read(), 2);
            end
        end
        ready_mode = 1;
        repeat (20) @(posedge clk);
        #1;
        chk("rnd_drained", 32'(mq.size()), 32'd0);
        chk("rnd_wr_count", 32'(wr_count), 32'(m_cnt));
        chk("rnd_flags", {28'b0, sleep_out, disp_on, err_ovf, err_seq},
            {28'b0, m_sleep, m_disp, m_ovf, m_err});

        // Reset asserted mid-write; strobe completes while in reset
        @(posedge clk); #1;
        bus.LCD_CS = 1'b0; bus.LCD_RS = 1'b0; bus.LCD_DATA_I = 16'h2C00; bus.LCD_WR = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.LCD_WR = 1'b1; bus.LCD_CS = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_reset();
        seen = 1'b0;
        repeat (20) begin @(posedge clk); #1; seen |= bus.ev_valid; end
        chk("mid_rst_no_event", 32'(seen), 32'd0);
        chk("mid_rst_wr_count", 32'(wr_count), 32'd0);
        chk("mid_rst_flags", {27'b0, bus.LCD_DATA_OE, sleep_out, disp_on, err_ovf, err_seq}, 32'd0);
        bus_write(1'b0, 16'h3600, 1'b1);
        chk("post_rst_wr_count", 32'(wr_count), 32'd1);
        bus_read("post_rst_rd", 16'h0000, 2);
        repeat (10) @(posedge clk);
        #1 chk("final_drained", 32'(mq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
